// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the Nandgame CPU fetch path: fetch handshake, execute wait, PC advance/jump.
// Define PC_SEQ_RETIRE_CNT_EN to build the retired-instruction counter; otherwise retire_cnt is tied to zero.

module OptimalIncrement #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    output logic [WIDTH-1:0] sum_o
);
    // Half-adder ripple chain with a constant carry-in of one; the final carry-out is dropped so the count wraps.
    logic [WIDTH-1:0] carry;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign sum_o[i] = a_i[i] ^ carry[i];
        if (i < WIDTH - 1) begin : g_carry
            assign carry[i+1] = a_i[i] & carry[i];
        end
    end
endmodule

module pc_sequencer #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 halt_req,
    output logic                 fetch_valid,
    output logic [15:0]          fetch_addr,
    input  logic                 fetch_ready,
    input  logic                 exec_done,
    input  logic                 jump_en,
    input  logic [15:0]          jump_addr,
    output logic [15:0]          pc,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] retire_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXEC,
        HALTED
    } state_e;

    state_e      state_q;
    logic [15:0] pc_q;
    logic [15:0] pc_d;
    logic [15:0] pc_inc;
    logic        fetch_valid_q;
    logic        halted_q;

    OptimalIncrement #(
        .WIDTH(16)
    ) u_inc (
        .a_i  (pc_q),
        .sum_o(pc_inc)
    );

    always_comb begin
        pc_d = jump_en ? jump_addr : pc_inc;
    end

    // A halt request is only honoured at the end of an instruction, so FETCH never withdraws its request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            fetch_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q       <= FETCH;
                        fetch_valid_q <= 1'b1;
                    end
                end
                FETCH: begin
                    if (fetch_ready) begin
                        state_q       <= EXEC;
                        fetch_valid_q <= 1'b0;
                    end
                end
                EXEC: begin
                    if (exec_done) begin
                        pc_q <= pc_d;
                        if (halt_req) begin
                            state_q  <= HALTED;
                            halted_q <= 1'b1;
                        end else begin
                            state_q       <= FETCH;
                            fetch_valid_q <= 1'b1;
                        end
                    end
                end
                HALTED: begin
                    if (start && !halt_req) begin
                        state_q       <= FETCH;
                        halted_q      <= 1'b0;
                        fetch_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    fetch_valid_q <= 1'b0;
                    halted_q      <= 1'b0;
                end
            endcase
        end
    end

    assign fetch_valid = fetch_valid_q;
    assign fetch_addr  = pc_q;
    assign pc          = pc_q;
    assign halted      = halted_q;

`ifdef PC_SEQ_RETIRE_CNT_EN
    logic [CNT_WIDTH-1:0] retire_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt_q <= '0;
        end else if (state_q == EXEC && exec_done) begin
            retire_cnt_q <= retire_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign retire_cnt = retire_cnt_q;
`else
    assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: instruction-level reference model compared every cycle plus directed literal checks.
// Honours PC_SEQ_RETIRE_CNT_EN the same way the design does.

module tb_pc_sequencer;

    localparam logic [15:0] RST_PC = 16'h0100;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        halt_req;
    logic        fetch_valid;
    logic [15:0] fetch_addr;
    logic        fetch_ready;
    logic        exec_done;
    logic        jump_en;
    logic [15:0] jump_addr;
    logic [15:0] pc;
    logic        halted;
    logic [15:0] retire_cnt;

    int checkCount = 0;
    int passCount  = 0;

    pc_sequencer #(
        .RESET_PC (RST_PC),
        .CNT_WIDTH(16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .halt_req   (halt_req),
        .fetch_valid(fetch_valid),
        .fetch_addr (fetch_addr),
        .fetch_ready(fetch_ready),
        .exec_done  (exec_done),
        .jump_en    (jump_en),
        .jump_addr  (jump_addr),
        .pc         (pc),
        .halted     (halted),
        .retire_cnt (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: where the processor is in its instruction life cycle, the PC and retirements.
    bit          waitingMem;
    bit          running;
    bit          stopped;
    logic [15:0] modelPc;
    logic [15:0] retired;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waitingMem = 1'b0;
            running    = 1'b0;
            stopped    = 1'b0;
            modelPc    = RST_PC;
            retired    = 16'd0;
        end else if (running) begin
            if (exec_done) begin
                modelPc = jump_en ? jump_addr : 16'((32'(modelPc) + 1) % 65536);
                retired = retired + 16'd1;
                running = 1'b0;
                if (halt_req) stopped = 1'b1;
                else waitingMem = 1'b1;
            end
        end else if (waitingMem) begin
            if (fetch_ready) begin
                waitingMem = 1'b0;
                running    = 1'b1;
            end
        end else if (stopped) begin
            if (start && !halt_req) begin
                stopped    = 1'b0;
                waitingMem = 1'b1;
            end
        end else if (start) begin
            waitingMem = 1'b1;
        end
    end

    function automatic logic [15:0] expRetire();
`ifdef PC_SEQ_RETIRE_CNT_EN
        return retired;
`else
        return 16'd0;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    endtask

    always @(negedge clk) begin
        checkOutput("model.fetch_valid", 32'(fetch_valid), 32'(waitingMem));
        checkOutput("model.fetch_addr", 32'(fetch_addr), 32'(modelPc));
        checkOutput("model.pc", 32'(pc), 32'(modelPc));
        checkOutput("model.halted", 32'(halted), 32'(stopped));
        checkOutput("model.retire_cnt", 32'(retire_cnt), 32'(expRetire()));
    end

    task automatic applyStimulus(input logic s, input logic h, input logic fr,
                                 input logic ed, input logic je, input logic [15:0] ja);
        start       = s;
        halt_req    = h;
        fetch_ready = fr;
        exec_done   = ed;
        jump_en     = je;
        jump_addr   = ja;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, required finish before 100000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] retireExp;
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        #12;
        // T1 reset values
        checkOutput("T1.pc", 32'(pc), 32'h0100);
        checkOutput("T1.fetch_valid", 32'(fetch_valid), 32'h0);
        checkOutput("T1.halted", 32'(halted), 32'h0);
        checkOutput("T1.retire_cnt", 32'(retire_cnt), 32'h0);
        #1 rst_n = 1'b1;
        tick();

        // T2 straight-line: first fetch at reset PC, jump to 0, then four sequential fetches
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        tick();
        checkOutput("T2.first_valid", 32'(fetch_valid), 32'h1);
        checkOutput("T2.first_addr", 32'(fetch_addr), 32'h0100);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000);
        tick();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
            checkOutput("T2.seq_valid", 32'(fetch_valid), 32'h1);
            checkOutput("T2.seq_addr", 32'(fetch_addr), 32'(i));
            tick();
            checkOutput("T2.exec_valid", 32'(fetch_valid), 32'h0);
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
            tick();
        end

        // T3 backpressure, slow execute, jump, and exec_done ignored while fetching
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("T3.held_valid", 32'(fetch_valid), 32'h1);
            checkOutput("T3.held_addr", 32'(fetch_addr), 32'h0004);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234);
        tick();
        checkOutput("T3.jump_addr", 32'(fetch_addr), 32'h1234);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h5555);
        tick();
        checkOutput("T3.fetch_ignores_done", 32'(fetch_addr), 32'h1234);

        // T4 wrap from FFFF to 0000
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'hFFFF);
        tick();
        checkOutput("T4.at_ffff", 32'(fetch_addr), 32'hFFFF);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        tick();
        checkOutput("T4.wrap_addr", 32'(fetch_addr), 32'h0000);
        checkOutput("T4.wrap_valid", 32'(fetch_valid), 32'h1);

        // T5 halt requested during the fetch of 0005
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0005);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        checkOutput("T5.fetch_not_withdrawn", 32'(fetch_valid), 32'h1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        tick();
        checkOutput("T5.halted", 32'(halted), 32'h1);
        checkOutput("T5.halt_pc", 32'(pc), 32'h0006);
        checkOutput("T5.halt_no_fetch", 32'(fetch_valid), 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h7777);
        tick();
        checkOutput("T5.halt_wins", 32'(halted), 32'h1);
        checkOutput("T5.pc_frozen", 32'(pc), 32'h0006);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        checkOutput("T5.resume_addr", 32'(fetch_addr), 32'h0006);
        checkOutput("T5.resume_halted", 32'(halted), 32'h0);

        // T6 async reset in EXEC at 0042, then three retirements
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0042);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        tick();
        checkOutput("T6.pre_pc", 32'(pc), 32'h0042);
        checkOutput("T6.pre_valid", 32'(fetch_valid), 32'h0);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("T6.async_pc", 32'(pc), 32'h0100);
        checkOutput("T6.async_valid", 32'(fetch_valid), 32'h0);
        checkOutput("T6.async_halted", 32'(halted), 32'h0);
        checkOutput("T6.async_cnt", 32'(retire_cnt), 32'h0);
        #2 rst_n = 1'b1;
        tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
            tick();
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
            tick();
        end
`ifdef PC_SEQ_RETIRE_CNT_EN
        retireExp = 16'd3;
`else
        retireExp = 16'd0;
`endif
        checkOutput("T6.retire_cnt", 32'(retire_cnt), 32'(retireExp));
        checkOutput("T6.final_addr", 32'(fetch_addr), 32'h0103);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        tick();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
